// File: rtl/mips_pkg.sv
// Shared fetch-side types: the queued instruction-pair record and the next-PC source encoding.
package mips_pkg;

   localparam int unsigned FETCH_PAIR_BYTES = 8;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr0;
      logic [31:0] instr1;
      logic        ok0;
      logic        ok1;
   } fetch_pair_t;

   typedef enum logic [2:0] {
      NEXTPC_RST    = 3'd0,
      NEXTPC_REDIR0 = 3'd1,
      NEXTPC_REDIR1 = 3'd2,
      NEXTPC_HOLD   = 3'd3,
      NEXTPC_PRED   = 3'd4,
      NEXTPC_SEQ    = 3'd5
   } nextpc_sel_e;

   function automatic logic [31:0] pair_base(input logic [31:0] pc);
      return {pc[31:3], 3'b000};
   endfunction

endpackage

// File: rtl/pair_fifo.sv
// Circular queue of fetched instruction pairs with a synchronous flush that empties it in one cycle.
module pair_fifo
   import mips_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush_i,
   input  logic                     enq_i,
   input  fetch_pair_t              enq_data_i,
   input  logic                     deq_i,
   output fetch_pair_t              head_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     empty_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

   fetch_pair_t   mem_q [DEPTH];
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          do_enq_s, do_deq_s;

   assign full_o   = (count_q == DEPTH_C);
   assign empty_o  = (count_q == '0);
   assign do_enq_s = enq_i & ~full_o;
   assign do_deq_s = deq_i & ~empty_o;
   assign count_o  = count_q;
   assign head_o   = mem_q[rd_ptr_q];

   // Pointer and occupancy next state; flush wins over any enqueue/dequeue.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_enq_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (do_deq_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({do_enq_s, do_deq_s})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload storage; contents are only meaningful below count, so no reset is needed.
   always_ff @(posedge clk) begin
      if (do_enq_s && !flush_i && !reset) begin
         mem_q[wr_ptr_q] <= enq_data_i;
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Owns the dual-issue fetch PC, picks the next PC by priority and queues fetched pairs for decode.
module fetch_sequencer
   import mips_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   stallf,
   output logic [31:0]            fetch_pc,
   input  logic [31:0]            fetch_instr0,
   input  logic [31:0]            fetch_instr1,
   input  logic                   pred_taken,
   input  logic [31:0]            pred_target,
   input  logic                   redir0_valid,
   input  logic [31:0]            redir0_target,
   input  logic                   redir1_valid,
   input  logic [31:0]            redir1_target,
   output logic                   deq_valid,
   input  logic                   deq_ready,
   output logic [31:0]            deq_pc,
   output logic [31:0]            deq_instr0,
   output logic [31:0]            deq_instr1,
   output logic                   deq_slot0_ok,
   output logic                   deq_slot1_ok,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic [31:0] base_s, seq_pc_s;
   logic        redirect_s, enq_s, deq_s, slot0_taken_s;
   nextpc_sel_e sel_s;
   fetch_pair_t enq_pair_s, head_s;

   assign redirect_s = redir0_valid | redir1_valid;
   assign enq_s      = ~stallf & ~full & ~redirect_s;
   assign deq_valid  = ~empty & ~redirect_s;
   assign deq_s      = deq_valid & deq_ready;
   assign base_s     = pair_base(fetch_pc_q);
   assign seq_pc_s   = base_s + 32'(FETCH_PAIR_BYTES);

   // A taken slot-0 branch whose target is not the fall-through word takes slot 1 off the path.
   assign slot0_taken_s = ~fetch_pc_q[2] & pred_taken & (pred_target != (base_s + 32'd4));

   assign enq_pair_s.pc     = base_s;
   assign enq_pair_s.instr0 = fetch_instr0;
   assign enq_pair_s.instr1 = fetch_instr1;
   assign enq_pair_s.ok0    = ~fetch_pc_q[2];
   assign enq_pair_s.ok1    = ~slot0_taken_s;

   // Next-PC source selection, highest priority first.
   always_comb begin
      sel_s = NEXTPC_SEQ;
      if (reset) begin
         sel_s = NEXTPC_RST;
      end else if (redir0_valid) begin
         sel_s = NEXTPC_REDIR0;
      end else if (redir1_valid) begin
         sel_s = NEXTPC_REDIR1;
      end else if (stallf || full) begin
         sel_s = NEXTPC_HOLD;
      end else if (pred_taken) begin
         sel_s = NEXTPC_PRED;
      end else begin
         sel_s = NEXTPC_SEQ;
      end
   end

   // Next-PC value mux.
   always_comb begin
      fetch_pc_d = fetch_pc_q;
      case (sel_s)
         NEXTPC_RST:    fetch_pc_d = RESET_PC;
         NEXTPC_REDIR0: fetch_pc_d = redir0_target;
         NEXTPC_REDIR1: fetch_pc_d = redir1_target;
         NEXTPC_HOLD:   fetch_pc_d = fetch_pc_q;
         NEXTPC_PRED:   fetch_pc_d = pred_target;
         NEXTPC_SEQ:    fetch_pc_d = seq_pc_s;
         default:       fetch_pc_d = RESET_PC;
      endcase
   end

   // Fetch PC register.
   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
      end else begin
         fetch_pc_q <= fetch_pc_d;
      end
   end

   assign fetch_pc = fetch_pc_q;

   pair_fifo #(
      .DEPTH (DEPTH)
   ) u_pair_fifo (
      .clk        (clk),
      .reset      (reset),
      .flush_i    (redirect_s),
      .enq_i      (enq_s),
      .enq_data_i (enq_pair_s),
      .deq_i      (deq_s),
      .head_o     (head_s),
      .count_o    (count),
      .full_o     (full),
      .empty_o    (empty)
   );

   assign deq_pc       = deq_valid ? head_s.pc     : 32'h0000_0000;
   assign deq_instr0   = deq_valid ? head_s.instr0 : 32'h0000_0000;
   assign deq_instr1   = deq_valid ? head_s.instr1 : 32'h0000_0000;
   assign deq_slot0_ok = deq_valid ? head_s.ok0    : 1'b0;
   assign deq_slot1_ok = deq_valid ? head_s.ok1    : 1'b0;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a reference PC plus a scoreboard queue of expected pairs.
module tb_fetch_sequencer;
   import mips_pkg::*;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset, stallf, pred_taken, redir0_valid, redir1_valid, deq_ready;
   logic [31:0] fetch_instr0, fetch_instr1, pred_target, redir0_target, redir1_target;
   logic [31:0] fetch_pc, deq_pc, deq_instr0, deq_instr1;
   logic        deq_valid, deq_slot0_ok, deq_slot1_ok, full, empty;
   logic [2:0]  count;

   int          checks = 0;
   int          errors = 0;
   fetch_pair_t sb[$];
   logic [31:0] m_pc;
   logic [31:0] saved_pc;

   always #5 clk = ~clk;

   fetch_sequencer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .reset(reset), .stallf(stallf), .fetch_pc(fetch_pc),
      .fetch_instr0(fetch_instr0), .fetch_instr1(fetch_instr1),
      .pred_taken(pred_taken), .pred_target(pred_target),
      .redir0_valid(redir0_valid), .redir0_target(redir0_target),
      .redir1_valid(redir1_valid), .redir1_target(redir1_target),
      .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_pc(deq_pc),
      .deq_instr0(deq_instr0), .deq_instr1(deq_instr1),
      .deq_slot0_ok(deq_slot0_ok), .deq_slot1_ok(deq_slot1_ok),
      .count(count), .full(full), .empty(empty)
   );

   function automatic logic [31:0] mem0(input logic [31:0] pc);
      return {pc[31:3], 3'b000} ^ 32'hA5A5_0000;
   endfunction

   function automatic logic [31:0] mem1(input logic [31:0] pc);
      return ({pc[31:3], 3'b000} + 32'd4) ^ 32'h5A5A_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: present instrmem data, check outputs at negedge, advance the reference model.
   task automatic cyc();
      logic        redir, m_full;
      logic [31:0] base;
      fetch_pair_t h, e;
      fetch_instr0 = mem0(m_pc);
      fetch_instr1 = mem1(m_pc);
      @(negedge clk);
      redir = redir0_valid | redir1_valid;
      chk("fetch_pc", fetch_pc, m_pc);
      chk("count", 32'(count), 32'(sb.size()));
      chk("empty", 32'(empty), 32'(sb.size() == 0));
      chk("full", 32'(full), 32'(sb.size() == DEPTH));
      chk("deq_valid", 32'(deq_valid), 32'((sb.size() != 0) && !redir));
      if (sb.size() != 0 && !redir && !reset && deq_ready) begin
         h = sb[0];
         chk("deq_pc", deq_pc, h.pc);
         chk("deq_instr0", deq_instr0, h.instr0);
         chk("deq_instr1", deq_instr1, h.instr1);
         chk("deq_ok0", 32'(deq_slot0_ok), 32'(h.ok0));
         chk("deq_ok1", 32'(deq_slot1_ok), 32'(h.ok1));
      end else if (sb.size() == 0) begin
         chk("deq_pc_idle", deq_pc, 32'h0000_0000);
      end
      if (reset) begin
         sb.delete();
         m_pc = RESET_PC;
      end else if (redir) begin
         sb.delete();
         m_pc = redir0_valid ? redir0_target : redir1_target;
      end else begin
         m_full = (sb.size() == DEPTH);
         base   = {m_pc[31:3], 3'b000};
         if (deq_ready && sb.size() != 0) void'(sb.pop_front());
         if (!stallf && !m_full) begin
            e.pc     = base;
            e.instr0 = mem0(m_pc);
            e.instr1 = mem1(m_pc);
            e.ok0    = !m_pc[2];
            e.ok1    = !(!m_pc[2] && pred_taken && (pred_target != base + 32'd4));
            sb.push_back(e);
         end
         if (!(stallf || m_full)) m_pc = pred_taken ? pred_target : base + 32'd8;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic redirect0(input logic [31:0] t);
      redir0_valid = 1'b1; redir0_target = t;
      cyc();
      redir0_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; stallf = 1'b0; pred_taken = 1'b0; pred_target = 32'h0;
      redir0_valid = 1'b0; redir0_target = 32'h0; redir1_valid = 1'b0; redir1_target = 32'h0;
      deq_ready = 1'b1; fetch_instr0 = 32'h0; fetch_instr1 = 32'h0;
      @(posedge clk); #1;
      m_pc = RESET_PC;
      sb.delete();
      cyc();

      // Streaming with decode always ready.
      reset = 1'b0;
      repeat (5) cyc();
      chk("seq_pc_40", fetch_pc, 32'd40);

      // Fill to full with decode stalled, then drain in order.
      reset = 1'b1; cyc(); reset = 1'b0;
      deq_ready = 1'b0;
      repeat (6) cyc();
      chk("full_pc_hold", fetch_pc, 32'd32);
      chk("full_count", 32'(count), 32'd4);
      chk("full_flag", 32'(full), 32'd1);
      deq_ready = 1'b1;
      repeat (6) cyc();

      // Redirect flushes three queued pairs; unaligned target kills slot 0.
      reset = 1'b1; cyc(); reset = 1'b0;
      deq_ready = 1'b0;
      repeat (3) cyc();
      redirect0(32'h0000_0104);
      chk("redir_pc", fetch_pc, 32'h0000_0104);
      chk("redir_count", 32'(count), 32'd0);
      deq_ready = 1'b1;
      cyc();
      chk("redir_seq_pc", fetch_pc, 32'h0000_0108);
      cyc();

      // Both redirects: slot 0 wins.
      redir0_valid = 1'b1; redir0_target = 32'h0000_0200;
      redir1_valid = 1'b1; redir1_target = 32'h0000_0300;
      cyc();
      redir0_valid = 1'b0; redir1_valid = 1'b0;
      chk("both_redir_pc", fetch_pc, 32'h0000_0200);
      cyc();

      // Predicted-taken slot 0: far target drops slot 1, fall-through target keeps it.
      redirect0(32'h0000_0040);
      pred_taken = 1'b1; pred_target = 32'h0000_0080;
      cyc();
      pred_taken = 1'b0;
      chk("pred_pc_80", fetch_pc, 32'h0000_0080);
      cyc();
      redirect0(32'h0000_0040);
      pred_taken = 1'b1; pred_target = 32'h0000_0044;
      cyc();
      pred_taken = 1'b0;
      chk("pred_pc_44", fetch_pc, 32'h0000_0044);
      repeat (2) cyc();

      // Hint at an unaligned PC does not affect slot 1.
      redir1_valid = 1'b1; redir1_target = 32'h0000_020C;
      cyc();
      redir1_valid = 1'b0;
      pred_taken = 1'b1; pred_target = 32'h0000_0300;
      cyc();
      pred_taken = 1'b0;
      repeat (2) cyc();

      // Stall drains the queue, redirect overrides the stall, reset overrides everything.
      deq_ready = 1'b0;
      repeat (2) cyc();
      saved_pc = m_pc;
      stallf = 1'b1; deq_ready = 1'b1;
      repeat (3) cyc();
      chk("stall_pc_frozen", fetch_pc, saved_pc);
      chk("stall_empty", 32'(empty), 32'd1);
      redirect0(32'h0000_0500);
      chk("stall_redir_pc", fetch_pc, 32'h0000_0500);
      cyc();
      reset = 1'b1; cyc(); reset = 1'b0;
      chk("stall_reset_pc", fetch_pc, RESET_PC);
      chk("stall_reset_count", 32'(count), 32'd0);
      stallf = 1'b0;
      cyc();

      // Sequential PC wraps from the top pair to zero.
      redir1_valid = 1'b1; redir1_target = 32'hFFFF_FFF8;
      cyc();
      redir1_valid = 1'b0;
      cyc();
      chk("wrap_pc", fetch_pc, 32'h0000_0000);
      repeat (2) cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
